cpu64_l1_arrays_pipe: RTL and testbench
=======================================

// Module: cpu64_l1_arrays_pipe
// PURPOSE
//  Parametrised L1 tag/data/valid/dirty store with registered 1-cycle lookup, per-way tag compare, hit/victim select.
//  Invalidate-all is a sequenced sweep (one set/cycle) instead of a single-cycle clear.
//  Sits under the L1 cache controller; serves one lookup port and one write/fill port per cycle.
// PARAMETERS
//  WAYS 8 : associativity, power of 2, >=2
//  SETS 64 : number of sets, power of 2
//  WORDS_PER_LINE 8 : DATA_W words per line, power of 2
//  DATA_W 64 : word width, multiple of 8
//  TAG_W 52 : tag width
//  Derived: IDX_W=clog2(SETS), WRD_W=clog2(WORDS_PER_LINE), WAY_W=clog2(WAYS), BE_W=DATA_W/8
// PORTS
//  clk_i in 1 : clock, single domain
//  rst_ni in 1 : asynchronous active-low reset
//  ready_o out 1 : high when the lookup and write ports may be used; low during invalidate sweep
//  req_valid_i in 1 : lookup request; accepted when req_valid_i && ready_o
//  req_index_i in IDX_W : lookup set
//  req_word_i in WRD_W : lookup word
//  req_tag_i in TAG_W : compare tag
//  rsp_valid_o out 1 : response valid, one cycle after acceptance
//  rsp_hit_o out 1 : some valid way tag == req_tag_i
//  rsp_hit_way_o out WAY_W : hitting way (lowest if several match)
//  rsp_rdata_o out DATA_W : data word of hitting way; 0 on miss
//  rsp_valid_way_o out WAYS : per-way valid bits of set
//  rsp_dirty_way_o out WAYS : per-way dirty bits of set
//  rsp_victim_way_o out WAY_W : lowest invalid way, else set's round-robin pointer
//  rsp_victim_tag_o out TAG_W : tag of victim way (writeback address)
//  rsp_victim_dirty_o out 1 : victim is valid and dirty
//  wr_en_i in 1 : write; performed when wr_en_i && ready_o
//  wr_index_i / wr_word_i / wr_way_i in IDX_W / WRD_W / WAY_W : write target
//  wr_be_i in BE_W : byte enables for data word; 0 = no data change
//  wr_data_i in DATA_W : write data
//  wr_tag_en_i in 1 : also write tag, valid, dirty of target way
//  wr_tag_i in TAG_W : tag value
//  wr_set_valid_i / wr_set_dirty_i in 1 / 1 : valid/dirty values, used when wr_tag_en_i
//  inv_start_i in 1 : start invalidate-all sweep; ignored unless idle
//  inv_busy_o out 1 : sweep in progress
//  inv_done_o out 1 : one-cycle pulse after last set cleared
// BEHAVIOUR
//  Reset: all outputs 0 except ready_o=1; all valid/dirty=0; all RR pointers=0; FSM IDLE; data/tag not reset.
//  Lookup latency 1: accepted at N -> rsp_* registered at N+1 from array state at end of N, pre-write (read-first).
//  rsp_valid_o=0 in cycles with no accepted request; other rsp_* hold last value.
//  Write: data word = (wr_data_i & mask) | (old & ~mask), mask byte b = 8'hFF if wr_be_i[b].
//  Write with wr_tag_en_i: tag/valid/dirty <= inputs; RR pointer of wr_index_i <= (wr_way_i+1) mod WAYS (wraps).
//  Same-cycle lookup and write, same location: response shows old data/tag/valid/dirty; new values visible from N+1.
//  Victim: lowest-numbered invalid way; if all valid, RR pointer. Dirty bits never cleared silently except by sweep/reset.
//  FSM IDLE -> SWEEP on inv_start_i (cnt=0); SWEEP: clear valid/dirty of set cnt, cnt++.
//  SWEEP -> IDLE after cnt=SETS-1 cleared; inv_done_o pulses that next cycle. Sweep lasts exactly SETS cycles.
//  During SWEEP: ready_o=0, inv_busy_o=1, req/wr ignored, RR pointers untouched.
//  Start cycle: ready_o still 1; same-cycle req and wr are performed; wr's valid/dirty later cleared by sweep.
//  inv_start_i while busy: ignored.
//  Sweep discards dirty lines without writeback; controller flushes first.
//  Reset mid-sweep: aborts immediately to reset state.
// STRUCTURE
//  Shared package cpu64_l1_pkg: clog2 function, default geometry constants, BE mask helper.
//  Sub-module cpu64_l1_victim_sel: combinational valid vector + RR pointer -> victim way (priority encoder/mux).
//  Top: arrays, RR pointer regs, sweep FSM/counter, registered response stage.
// TESTING
//  Reset, lookup idx 0 tag 0 -> rsp_valid_o=1, hit=0, victim_way=0, victim_dirty=0, ready_o=1.
//  Write way 3 idx 5 word 2 data 64'h1122334455667788 tag 'hABC valid -> lookup next cycle hit=1, way=3, rdata matches.
//  Then wr_be_i=8'h0F data 64'hFFFFFFFFFFFFFFFF, no tag_en -> read 64'h11223344FFFFFFFF, valid/dirty unchanged.
//  Fill all 8 ways of set 9 in order 0..7 -> victim=0 (ptr wrapped); tag write way 0 -> victim=1; way 5 dirty -> victim_dirty only when victim=5.
//  Same-cycle lookup+write to idx 5 word 2 -> response old data; next lookup new data.
//  inv_start_i -> busy/ready_o=0 for 64 cycles, done pulse cycle 65, all lookups miss; restart while busy ignored;
//  rst_ni low at cnt 20 -> busy=0, ready_o=1 at once.

Source files
------------

// File: rtl/cpu64_l1_arrays_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu64_l1_pkg
// Shared definitions for the L1 tag/data/valid/dirty arrays:
//   - default cache geometry constants
//   - sweep FSM state type
//   - clog2 for deriving index/way/word widths
//   - be_mask: expands a byte-enable vector into a bit mask
// No ports (package).
// -----------------------------------------------------------------------------
package cpu64_l1_pkg;

  localparam int DEF_WAYS           = 8;
  localparam int DEF_SETS           = 64;
  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_DATA_W         = 64;
  localparam int DEF_TAG_W          = 52;

  // Widest byte-enable vector be_mask accepts; callers zero-extend and slice.
  localparam int MAX_BE_W = 64;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } sweep_state_e;

  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  function automatic logic [MAX_BE_W*8-1:0] be_mask(input logic [MAX_BE_W-1:0] be);
    logic [MAX_BE_W*8-1:0] mask;
    for (int b = 0; b < MAX_BE_W; b++) mask[b*8 +: 8] = {8{be[b]}};
    return mask;
  endfunction

endpackage

// File: rtl/cpu64_l1_arrays_pipe_if.sv
// -----------------------------------------------------------------------------
// cpu64_l1_arrays_pipe_if
// Lookup, write/fill and invalidate-sweep signals between the L1 cache
// controller (master) and the L1 arrays (slave).
//   lookup : req_valid_i/req_index_i/req_word_i/req_tag_i, ready_o
//   result : rsp_* (registered, one cycle after acceptance)
//   write  : wr_* (data word with byte enables, optional tag/valid/dirty)
//   sweep  : inv_start_i, inv_busy_o, inv_done_o
// Signal suffixes are from the arrays' point of view.
// -----------------------------------------------------------------------------
interface cpu64_l1_arrays_pipe_if #(
  parameter int WAYS           = cpu64_l1_pkg::DEF_WAYS,
  parameter int SETS           = cpu64_l1_pkg::DEF_SETS,
  parameter int WORDS_PER_LINE = cpu64_l1_pkg::DEF_WORDS_PER_LINE,
  parameter int DATA_W         = cpu64_l1_pkg::DEF_DATA_W,
  parameter int TAG_W          = cpu64_l1_pkg::DEF_TAG_W
);
  localparam int IDX_W = cpu64_l1_pkg::clog2(SETS);
  localparam int WRD_W = cpu64_l1_pkg::clog2(WORDS_PER_LINE);
  localparam int WAY_W = cpu64_l1_pkg::clog2(WAYS);
  localparam int BE_W  = DATA_W / 8;

  logic              ready_o;
  logic              req_valid_i;
  logic [IDX_W-1:0]  req_index_i;
  logic [WRD_W-1:0]  req_word_i;
  logic [TAG_W-1:0]  req_tag_i;

  logic              rsp_valid_o;
  logic              rsp_hit_o;
  logic [WAY_W-1:0]  rsp_hit_way_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic [WAYS-1:0]   rsp_valid_way_o;
  logic [WAYS-1:0]   rsp_dirty_way_o;
  logic [WAY_W-1:0]  rsp_victim_way_o;
  logic [TAG_W-1:0]  rsp_victim_tag_o;
  logic              rsp_victim_dirty_o;

  logic              wr_en_i;
  logic [IDX_W-1:0]  wr_index_i;
  logic [WRD_W-1:0]  wr_word_i;
  logic [WAY_W-1:0]  wr_way_i;
  logic [BE_W-1:0]   wr_be_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_tag_en_i;
  logic [TAG_W-1:0]  wr_tag_i;
  logic              wr_set_valid_i;
  logic              wr_set_dirty_i;

  logic              inv_start_i;
  logic              inv_busy_o;
  logic              inv_done_o;

  modport master (
    input  ready_o, rsp_valid_o, rsp_hit_o, rsp_hit_way_o, rsp_rdata_o,
           rsp_valid_way_o, rsp_dirty_way_o, rsp_victim_way_o,
           rsp_victim_tag_o, rsp_victim_dirty_o, inv_busy_o, inv_done_o,
    output req_valid_i, req_index_i, req_word_i, req_tag_i,
           wr_en_i, wr_index_i, wr_word_i, wr_way_i, wr_be_i, wr_data_i,
           wr_tag_en_i, wr_tag_i, wr_set_valid_i, wr_set_dirty_i, inv_start_i
  );

  modport slave (
    output ready_o, rsp_valid_o, rsp_hit_o, rsp_hit_way_o, rsp_rdata_o,
           rsp_valid_way_o, rsp_dirty_way_o, rsp_victim_way_o,
           rsp_victim_tag_o, rsp_victim_dirty_o, inv_busy_o, inv_done_o,
    input  req_valid_i, req_index_i, req_word_i, req_tag_i,
           wr_en_i, wr_index_i, wr_word_i, wr_way_i, wr_be_i, wr_data_i,
           wr_tag_en_i, wr_tag_i, wr_set_valid_i, wr_set_dirty_i, inv_start_i
  );
endinterface

// File: rtl/cpu64_l1_arrays_pipe_victim_sel.sv
// -----------------------------------------------------------------------------
// cpu64_l1_victim_sel
// Combinational replacement choice for one set: the lowest-numbered invalid
// way, or the set's round-robin pointer when every way is valid.
//   valid  in  WAYS  : per-way valid bits of the set
//   rr_ptr in  WAY_W : round-robin pointer of the set
//   victim out WAY_W : selected way
// -----------------------------------------------------------------------------
module cpu64_l1_victim_sel import cpu64_l1_pkg::*; #(
  parameter int WAYS  = DEF_WAYS,
  parameter int WAY_W = clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rr_ptr,
  output logic [WAY_W-1:0] victim
);

  // Scanning downward lets the lowest invalid way overwrite any higher one.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    victim = rr_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/cpu64_l1_arrays_pipe.sv
// -----------------------------------------------------------------------------
// cpu64_l1_arrays_pipe
// L1 tag/data/valid/dirty store with a registered one-cycle lookup, per-way
// tag compare, hit and victim selection, byte-enabled writes and a one
// set-per-cycle invalidate-all sweep.
//   clk_i  in : clock
//   rst_ni in : asynchronous active-low reset
//   bus       : cpu64_l1_arrays_pipe_if.slave (lookup, response, write, sweep)
// Lookups read the array state before the same-cycle write (read-first).
// -----------------------------------------------------------------------------
module cpu64_l1_arrays_pipe import cpu64_l1_pkg::*; #(
  parameter int WAYS           = DEF_WAYS,
  parameter int SETS           = DEF_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TAG_W          = DEF_TAG_W
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  cpu64_l1_arrays_pipe_if.slave bus
);
  localparam int IDX_W = clog2(SETS);
  localparam int WAY_W = clog2(WAYS);

  // Storage
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  // Sweep FSM
  sweep_state_e     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             sweep_clr;

  logic ready, req_fire, wr_fire, wr_meta;
  assign ready    = (state_q == ST_IDLE);
  assign req_fire = bus.req_valid_i && ready;
  assign wr_fire  = bus.wr_en_i && ready;
  assign wr_meta  = wr_fire && bus.wr_tag_en_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    sweep_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.inv_start_i) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        sweep_clr = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every lookup in this cycle sees pre-edge contents (read-first).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Data and tag arrays: only meaningful where valid is set.
  // NOTE: large memories are left unreset; valid bits alone qualify their contents.
  logic [DATA_W-1:0] wmask;
  assign wmask = DATA_W'(be_mask(MAX_BE_W'(bus.wr_be_i)));

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      data_q[bus.wr_index_i][bus.wr_way_i][bus.wr_word_i] <=
        (bus.wr_data_i & wmask) |
        (data_q[bus.wr_index_i][bus.wr_way_i][bus.wr_word_i] & ~wmask);
    end
    if (wr_meta) tag_q[bus.wr_index_i][bus.wr_way_i] <= bus.wr_tag_i;
  end

  // Valid/dirty/round-robin state. Writes and sweep clears never coincide
  // because writes need ready, which is low while sweeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (wr_meta) begin
        valid_q[bus.wr_index_i][bus.wr_way_i] <= bus.wr_set_valid_i;
        dirty_q[bus.wr_index_i][bus.wr_way_i] <= bus.wr_set_dirty_i;
        rr_q[bus.wr_index_i]                  <= bus.wr_way_i + 1'b1;
      end
      if (sweep_clr) begin
        valid_q[cnt_q] <= '0;
        dirty_q[cnt_q] <= '0;
      end
    end
  end

  // Lookup: per-way compare, lowest matching way wins.
  logic [WAYS-1:0]  set_valid, set_dirty, hit_vec;
  logic [WAY_W-1:0] hit_way, victim;
  assign set_valid = valid_q[bus.req_index_i];
  assign set_dirty = dirty_q[bus.req_index_i];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = set_valid[w] && (tag_q[bus.req_index_i][w] == bus.req_tag_i);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  cpu64_l1_victim_sel #(.WAYS(WAYS), .WAY_W(WAY_W)) u_victim_sel (
    .valid  (set_valid),
    .rr_ptr (rr_q[bus.req_index_i]),
    .victim (victim)
  );

  // Response stage: rsp_valid pulses per accepted request, payload holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.rsp_valid_o        <= 1'b0;
      bus.rsp_hit_o          <= 1'b0;
      bus.rsp_hit_way_o      <= '0;
      bus.rsp_rdata_o        <= '0;
      bus.rsp_valid_way_o    <= '0;
      bus.rsp_dirty_way_o    <= '0;
      bus.rsp_victim_way_o   <= '0;
      bus.rsp_victim_tag_o   <= '0;
      bus.rsp_victim_dirty_o <= 1'b0;
    end else begin
      bus.rsp_valid_o <= req_fire;
      if (req_fire) begin
        bus.rsp_hit_o          <= |hit_vec;
        bus.rsp_hit_way_o      <= hit_way;
        bus.rsp_rdata_o        <= (|hit_vec) ? data_q[bus.req_index_i][hit_way][bus.req_word_i] : '0;
        bus.rsp_valid_way_o    <= set_valid;
        bus.rsp_dirty_way_o    <= set_dirty;
        bus.rsp_victim_way_o   <= victim;
        bus.rsp_victim_tag_o   <= tag_q[bus.req_index_i][victim];
        bus.rsp_victim_dirty_o <= set_valid[victim] && set_dirty[victim];
      end
    end
  end

  assign bus.ready_o    = ready;
  assign bus.inv_busy_o = (state_q == ST_SWEEP);
  assign bus.inv_done_o = done_q;

endmodule

// File: tb/tb_cpu64_l1_arrays_pipe.sv
// -----------------------------------------------------------------------------
// tb_cpu64_l1_arrays_pipe
// Directed bench for cpu64_l1_arrays_pipe: a table of per-cycle
// {lookup, write, expected response} records plus hand-written sequences
// for the invalidate sweep and a reset that lands mid-sweep.
// -----------------------------------------------------------------------------
module tb_cpu64_l1_arrays_pipe;
  import cpu64_l1_pkg::*;

  localparam int WAYS = 8, SETS = 64, WORDS = 8, DATA_W = 64, TAG_W = 52;
  localparam int IDX_W = 6, WRD_W = 3, WAY_W = 3, BE_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu64_l1_arrays_pipe_if #(
    .WAYS(WAYS), .SETS(SETS), .WORDS_PER_LINE(WORDS), .DATA_W(DATA_W), .TAG_W(TAG_W)
  ) bus ();

  cpu64_l1_arrays_pipe #(
    .WAYS(WAYS), .SETS(SETS), .WORDS_PER_LINE(WORDS), .DATA_W(DATA_W), .TAG_W(TAG_W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    string             name;
    logic              req;
    logic [IDX_W-1:0]  ridx;
    logic [WRD_W-1:0]  rword;
    logic [TAG_W-1:0]  rtag;
    logic              wr;
    logic [IDX_W-1:0]  widx;
    logic [WRD_W-1:0]  wword;
    logic [WAY_W-1:0]  wway;
    logic [BE_W-1:0]   wbe;
    logic [DATA_W-1:0] wdata;
    logic              wtag_en;
    logic [TAG_W-1:0]  wtag;
    logic              wv;
    logic              wd;
    logic              exp_hit;
    logic [WAY_W-1:0]  exp_way;
    logic [DATA_W-1:0] exp_rdata;
    logic [WAYS-1:0]   exp_valid;
    logic [WAYS-1:0]   exp_dirty;
    logic [WAY_W-1:0]  exp_vic;
    logic              exp_vdirty;
    logic              chk_vtag;
    logic [TAG_W-1:0]  exp_vtag;
  } vec_t;

  vec_t p1[$];
  vec_t p2[$];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic vec_t nop(input string name);
    vec_t v;
    v.name = name;
    v.req = 1'b0; v.ridx = '0; v.rword = '0; v.rtag = '0;
    v.wr = 1'b0; v.widx = '0; v.wword = '0; v.wway = '0; v.wbe = '0; v.wdata = '0;
    v.wtag_en = 1'b0; v.wtag = '0; v.wv = 1'b0; v.wd = 1'b0;
    v.exp_hit = 1'b0; v.exp_way = '0; v.exp_rdata = '0; v.exp_valid = '0;
    v.exp_dirty = '0; v.exp_vic = '0; v.exp_vdirty = 1'b0;
    v.chk_vtag = 1'b0; v.exp_vtag = '0;
    return v;
  endfunction

  function automatic vec_t rd(input string name, input int idx, input int word,
                              input logic [63:0] tag, input int hit, input int way,
                              input logic [63:0] rdata, input int valid, input int dirty,
                              input int vic, input int vdirty);
    vec_t v = nop(name);
    v.req = 1'b1; v.ridx = IDX_W'(idx); v.rword = WRD_W'(word); v.rtag = TAG_W'(tag);
    v.exp_hit = (hit != 0); v.exp_way = WAY_W'(way); v.exp_rdata = rdata;
    v.exp_valid = WAYS'(valid); v.exp_dirty = WAYS'(dirty);
    v.exp_vic = WAY_W'(vic); v.exp_vdirty = (vdirty != 0);
    return v;
  endfunction

  function automatic vec_t wr(input vec_t vin, input int idx, input int word, input int way,
                              input int be, input logic [63:0] data, input int tag_en,
                              input logic [63:0] tag, input int val, input int dirty);
    vec_t v = vin;
    v.wr = 1'b1; v.widx = IDX_W'(idx); v.wword = WRD_W'(word); v.wway = WAY_W'(way);
    v.wbe = BE_W'(be); v.wdata = data; v.wtag_en = (tag_en != 0); v.wtag = TAG_W'(tag);
    v.wv = (val != 0); v.wd = (dirty != 0);
    return v;
  endfunction

  function automatic vec_t vt(input vec_t vin, input logic [63:0] tag);
    vec_t v = vin;
    v.chk_vtag = 1'b1;
    v.exp_vtag = TAG_W'(tag);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid_i = 1'b0; bus.req_index_i = '0; bus.req_word_i = '0; bus.req_tag_i = '0;
    bus.wr_en_i = 1'b0; bus.wr_index_i = '0; bus.wr_word_i = '0; bus.wr_way_i = '0;
    bus.wr_be_i = '0; bus.wr_data_i = '0; bus.wr_tag_en_i = 1'b0; bus.wr_tag_i = '0;
    bus.wr_set_valid_i = 1'b0; bus.wr_set_dirty_i = 1'b0; bus.inv_start_i = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.req_valid_i = v.req; bus.req_index_i = v.ridx; bus.req_word_i = v.rword;
    bus.req_tag_i = v.rtag;
    bus.wr_en_i = v.wr; bus.wr_index_i = v.widx; bus.wr_word_i = v.wword;
    bus.wr_way_i = v.wway; bus.wr_be_i = v.wbe; bus.wr_data_i = v.wdata;
    bus.wr_tag_en_i = v.wtag_en; bus.wr_tag_i = v.wtag;
    bus.wr_set_valid_i = v.wv; bus.wr_set_dirty_i = v.wd; bus.inv_start_i = 1'b0;
  endtask

  // One cycle: drive after the falling edge, sample 1 ns after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    drive_vec(v);
    @(posedge clk);
    #1;
    check({v.name, ".rsp_valid"}, 64'(bus.rsp_valid_o), 64'(v.req));
    check({v.name, ".ready"}, 64'(bus.ready_o), 64'd1);
    check({v.name, ".busy_done"}, 64'({bus.inv_busy_o, bus.inv_done_o}), 64'd0);
    if (v.req) begin
      check({v.name, ".hit"}, 64'(bus.rsp_hit_o), 64'(v.exp_hit));
      if (v.exp_hit) check({v.name, ".hit_way"}, 64'(bus.rsp_hit_way_o), 64'(v.exp_way));
      check({v.name, ".rdata"}, bus.rsp_rdata_o, v.exp_rdata);
      check({v.name, ".valid_way"}, 64'(bus.rsp_valid_way_o), 64'(v.exp_valid));
      check({v.name, ".dirty_way"}, 64'(bus.rsp_dirty_way_o), 64'(v.exp_dirty));
      check({v.name, ".victim"}, 64'(bus.rsp_victim_way_o), 64'(v.exp_vic));
      check({v.name, ".victim_dirty"}, 64'(bus.rsp_victim_dirty_o), 64'(v.exp_vdirty));
      if (v.chk_vtag) check({v.name, ".victim_tag"}, 64'(bus.rsp_victim_tag_o), 64'(v.exp_vtag));
    end
  endtask

  int  busy_cnt;
  int  rsp_cnt;
  logic done_seen;

  initial begin
    // ---------------- vector tables ----------------
    p1.push_back(rd("rst_lookup", 0, 0, 64'h0, 0, 0, 64'h0, 'h00, 'h00, 0, 0));
    p1.push_back(wr(nop("fill_a"), 5, 2, 3, 'hFF, 64'h1122334455667788, 1, 64'hABC, 1, 0));
    p1.push_back(rd("hit_a", 5, 2, 64'hABC, 1, 3, 64'h1122334455667788, 'h08, 'h00, 0, 0));
    p1.push_back(wr(nop("be_lo"), 5, 2, 3, 'h0F, 64'hFFFFFFFFFFFFFFFF, 0, 64'h0, 0, 0));
    p1.push_back(rd("hit_be", 5, 2, 64'hABC, 1, 3, 64'h11223344FFFFFFFF, 'h08, 'h00, 0, 0));
    p1.push_back(rd("miss_tag", 5, 2, 64'hABD, 0, 0, 64'h0, 'h08, 'h00, 0, 0));
    p1.push_back(wr(rd("same_cyc", 5, 2, 64'hABC, 1, 3, 64'h11223344FFFFFFFF, 'h08, 'h00, 0, 0),
                    5, 2, 3, 'hFF, 64'hDEADBEEFCAFEF00D, 1, 64'hABC, 1, 1));
    p1.push_back(rd("after_same", 5, 2, 64'hABC, 1, 3, 64'hDEADBEEFCAFEF00D, 'h08, 'h08, 0, 0));
    p1.push_back(wr(nop("be_81"), 5, 2, 3, 'h81, 64'h0102030405060708, 0, 64'h0, 0, 0));
    p1.push_back(rd("hit_81", 5, 2, 64'hABC, 1, 3, 64'h01ADBEEFCAFEF008, 'h08, 'h08, 0, 0));
    for (int w = 0; w < WAYS; w++) begin
      p1.push_back(wr(rd($sformatf("fill9_%0d", w), 9, 0, 64'h0, 0, 0, 64'h0,
                         (1 << w) - 1, (w > 5) ? 'h20 : 'h00, w, 0),
                      9, 0, w, 'hFF, 64'h9000 + 64'(w), 1, 64'h100 + 64'(w), 1, (w == 5) ? 1 : 0));
    end
    p1.push_back(vt(rd("full9", 9, 0, 64'h0, 0, 0, 64'h0, 'hFF, 'h20, 0, 0), 64'h100));
    p1.push_back(wr(nop("retag0"), 9, 0, 0, 'h00, 64'h0, 1, 64'h100, 1, 0));
    p1.push_back(vt(rd("hit9_0", 9, 0, 64'h100, 1, 0, 64'h9000, 'hFF, 'h20, 1, 0), 64'h101));
    p1.push_back(wr(nop("retag4"), 9, 0, 4, 'h00, 64'h0, 1, 64'h104, 1, 0));
    p1.push_back(vt(rd("vic5", 9, 0, 64'h0, 0, 0, 64'h0, 'hFF, 'h20, 5, 1), 64'h105));
    p1.push_back(wr(nop("dup_tag"), 9, 0, 6, 'h00, 64'h0, 1, 64'h103, 1, 0));
    p1.push_back(vt(rd("dup_hit", 9, 0, 64'h103, 1, 3, 64'h9003, 'hFF, 'h20, 7, 0), 64'h107));

    p2.push_back(rd("sw_5", 5, 2, 64'hABC, 0, 0, 64'h0, 'h00, 'h00, 0, 0));
    p2.push_back(rd("sw_9", 9, 0, 64'h100, 0, 0, 64'h0, 'h00, 'h00, 0, 0));
    p2.push_back(rd("sw_20", 20, 0, 64'h55, 0, 0, 64'h0, 'h00, 'h00, 0, 0));
    p2.push_back(rd("sw_30", 30, 0, 64'h77, 0, 0, 64'h0, 'h00, 'h00, 0, 0));

    // ---------------- reset ----------------
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 64'(bus.ready_o), 64'd1);
    check("rst.rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst.rsp_hit_rdata", 64'(bus.rsp_hit_o) | bus.rsp_rdata_o, 64'd0);
    check("rst.victim", 64'({bus.rsp_victim_way_o, bus.rsp_victim_dirty_o}), 64'd0);
    check("rst.busy_done", 64'({bus.inv_busy_o, bus.inv_done_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (p1[i]) apply(p1[i]);

    // ---------------- invalidate sweep ----------------
    // Start cycle: lookup and write are still performed.
    @(negedge clk);
    drive_idle();
    bus.inv_start_i = 1'b1;
    bus.req_valid_i = 1'b1; bus.req_index_i = 6'd5; bus.req_word_i = 3'd2; bus.req_tag_i = 52'hABC;
    bus.wr_en_i = 1'b1; bus.wr_index_i = 6'd20; bus.wr_way_i = 3'd2; bus.wr_tag_en_i = 1'b1;
    bus.wr_tag_i = 52'h55; bus.wr_set_valid_i = 1'b1; bus.wr_set_dirty_i = 1'b1;
    @(posedge clk);
    #1;
    check("sw_start.hit", 64'(bus.rsp_hit_o), 64'd1);
    check("sw_start.rdata", bus.rsp_rdata_o, 64'h01ADBEEFCAFEF008);
    check("sw_start.busy", 64'(bus.inv_busy_o), 64'd1);
    check("sw_start.ready", 64'(bus.ready_o), 64'd0);
    busy_cnt  = 1;
    rsp_cnt   = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      @(negedge clk);
      drive_idle();
      bus.inv_start_i = (c >= 5 && c <= 10);
      bus.req_valid_i = 1'b1; bus.req_index_i = 6'd30; bus.req_tag_i = 52'h77;
      bus.wr_en_i = 1'b1; bus.wr_index_i = 6'd30; bus.wr_way_i = 3'd1; bus.wr_be_i = 8'hFF;
      bus.wr_tag_en_i = 1'b1; bus.wr_tag_i = 52'h77; bus.wr_set_valid_i = 1'b1;
      bus.wr_set_dirty_i = 1'b1;
      @(posedge clk);
      #1;
      if (bus.inv_done_o) done_seen = 1'b1;
      else if (bus.inv_busy_o) busy_cnt++;
      if (bus.rsp_valid_o) rsp_cnt++;
    end
    check("sw.done_seen", 64'(done_seen), 64'd1);
    check("sw.busy_cycles", 64'(busy_cnt), 64'd64);
    check("sw.ignored_req", 64'(rsp_cnt), 64'd0);
    check("sw.done_ready", 64'({bus.ready_o, bus.inv_busy_o}), 64'b10);

    foreach (p2[i]) apply(p2[i]);

    // ---------------- reset in the middle of a sweep ----------------
    @(negedge clk);
    drive_idle();
    bus.inv_start_i = 1'b1;
    bus.wr_en_i = 1'b1; bus.wr_index_i = 6'd40; bus.wr_way_i = 3'd1; bus.wr_tag_en_i = 1'b1;
    bus.wr_tag_i = 52'h40; bus.wr_set_valid_i = 1'b1; bus.wr_set_dirty_i = 1'b1;
    @(posedge clk);
    #1;
    check("rs.busy_start", 64'(bus.inv_busy_o), 64'd1);
    @(negedge clk);
    drive_idle();
    repeat (20) @(posedge clk);
    #1;
    check("rs.busy_cnt20", 64'(bus.inv_busy_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rs.busy", 64'(bus.inv_busy_o), 64'd0);
    check("rs.ready", 64'(bus.ready_o), 64'd1);
    check("rs.done", 64'(bus.inv_done_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(rd("post_rst", 40, 0, 64'h40, 0, 0, 64'h0, 'h00, 'h00, 0, 0));

    @(negedge clk);
    drive_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
